// File: rtl/fp_mantissa_divider_pkg.sv
// Shared FPU definitions: sequencing state type and default significand width.
package fp_mantissa_divider_pkg;

    // Significand width including the hidden bit (single precision).
    localparam int unsigned FPU_N = 24;

    // Iterative-unit sequencing states, shared with the mantissa multiplier.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fpu_state_e;

endpackage

// File: rtl/fp_mantissa_divider_div_step.sv
// One restoring-division step: compare the partial remainder with the divisor,
// subtract when it fits, and report the resulting quotient bit.
module div_step
    import fp_mantissa_divider_pkg::*;
#(
    parameter int unsigned N = FPU_N
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] div,
    output logic         q_bit,
    output logic [N:0]   rem_sub
);

    // Compare/subtract; the remainder passes through unchanged when it is below the divisor.
    always_comb begin
        q_bit   = (rem >= {1'b0, div});
        rem_sub = q_bit ? (rem - {1'b0, div}) : rem;
    end

endmodule

// File: rtl/fp_mantissa_divider.sv
// Iterative restoring mantissa divider: Q = floor(M1 * 2^(N+1) / M2),
// one quotient bit per cycle, with a sticky bit for a nonzero remainder.
module fp_mantissa_divider
    import fp_mantissa_divider_pkg::*;
#(
    parameter int unsigned N = FPU_N
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [N-2:0] frac1,
    input  logic [N-2:0] frac2,
    output logic         busy,
    output logic         done,
    output logic [N+1:0] Q,
    output logic         sticky
);

    localparam int unsigned CW = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(N + 1);

    fpu_state_e    state;
    fpu_state_e    state_next;
    logic [N-1:0]  m2;
    logic [N:0]    rem;
    logic [N:0]    qreg;
    logic [CW-1:0] cnt;
    logic          q_bit;
    logic [N:0]    rem_sub;

    div_step #(.N(N)) u_step (
        .rem     (rem),
        .div     (m2),
        .q_bit   (q_bit),
        .rem_sub (rem_sub)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: N+2 CALC cycles, then a single DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath. The remainder register is loaded with M1, so it also serves as the
    // registered dividend. Q/sticky are written on the last CALC step so they are
    // already valid during the DONE cycle and otherwise hold their previous result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m2     <= '0;
            rem    <= '0;
            qreg   <= '0;
            cnt    <= '0;
            Q      <= '0;
            sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m2   <= {1'b1, frac2};
                        rem  <= {2'b01, frac1};
                        qreg <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    rem  <= {rem_sub[N-1:0], 1'b0};
                    qreg <= {qreg[N-1:0], q_bit};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        Q      <= {qreg, q_bit};
                        sticky <= |rem_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
